// File: rtl/types_pkg.sv
// Shared types for the functional-unit scheduler: FU codes and slot FSM states.
package types_pkg;

  typedef enum logic [1:0] {
    FU_ALU     = 2'd0,
    FU_SMEM    = 2'd1,
    FU_MATRIX  = 2'd2,
    FU_ILLEGAL = 2'd3
  } fu_t;

  localparam int NUM_FU = 3;

  typedef enum logic {
    SLOT_IDLE = 1'b0,
    SLOT_BUSY = 1'b1
  } slot_state_t;

endpackage

// File: rtl/fu_scheduler_if.sv
// Dispatch-side bundle between the dispatch latch and the FU scheduler.
//
// Handshake: dispatch holds disp_valid/disp_fu for the cycle; the scheduler
// answers combinationally in the same cycle. grant=1 means the instruction
// is taken at the next rising edge; freeze=1 means the target FU is busy and
// dispatch must hold. flush squashes the request so neither is raised.
// An illegal FU code never grants or freezes; illegal_err pulses one cycle later.
interface fu_scheduler_if;
  import types_pkg::*;

  logic              disp_valid;
  fu_t               disp_fu;
  logic              flush;
  logic              grant;
  logic              freeze;
  logic [NUM_FU-1:0] fu_busy;
  logic              illegal_err;

  modport master (
    output disp_valid, disp_fu, flush,
    input  grant, freeze, fu_busy, illegal_err
  );

  modport slave (
    input  disp_valid, disp_fu, flush,
    output grant, freeze, fu_busy, illegal_err
  );

endinterface

// File: rtl/fu_slot.sv
// One functional-unit slot: IDLE/BUSY FSM plus an 8-bit counter.
// FIXED_LAT=1: counter loads LAT on start and BUSY lasts exactly LAT cycles.
// FIXED_LAT=0: counter ages from 0; done releases, reaching TIMEOUT forces release.
module fu_slot
  import types_pkg::*;
#(
  parameter bit FIXED_LAT = 1'b0,
  parameter int LAT       = 0,
  parameter int TIMEOUT   = 200
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        done,
  output slot_state_t state,
  output logic        timeout_hit
);

  slot_state_t state_next;
  logic [7:0]  cnt;
  logic [7:0]  cnt_next;

  // State and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SLOT_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state logic; done outranks the timeout on the same edge.
  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    timeout_hit = 1'b0;
    case (state)
      SLOT_IDLE: begin
        if (start) begin
          if (FIXED_LAT) begin
            if (LAT != 0) begin
              state_next = SLOT_BUSY;
              cnt_next   = 8'(LAT);
            end
          end else begin
            state_next = SLOT_BUSY;
            cnt_next   = '0;
          end
        end
      end
      SLOT_BUSY: begin
        if (FIXED_LAT) begin
          if (cnt <= 8'd1) state_next = SLOT_IDLE;
          else             cnt_next   = cnt - 8'd1;
        end else if (done) begin
          state_next = SLOT_IDLE;
        end else if (cnt + 8'd1 == 8'(TIMEOUT)) begin
          state_next  = SLOT_IDLE;
          timeout_hit = 1'b1;
        end else begin
          cnt_next = cnt + 8'd1;
        end
      end
      default: state_next = SLOT_IDLE;
    endcase
  end

endmodule

// File: rtl/fu_scheduler.sv
// Functional-unit scheduler: grants dispatch requests to idle FUs, freezes
// dispatch on busy targets, tracks per-FU busy state, timeouts and grant count.
module fu_scheduler
  import types_pkg::*;
#(
  parameter int ALU_LAT = 2,
  parameter int TIMEOUT = 200
) (
  input  logic          CLK,
  input  logic          nRST,
  fu_scheduler_if.slave disp,
  input  logic          smem_done,
  input  logic          mat_done,
  output logic [1:0]    timeout_err,
  output logic [15:0]   issue_cnt
);

  slot_state_t       alu_state;
  slot_state_t       smem_state;
  slot_state_t       mat_state;
  logic [NUM_FU-1:0] busy;
  logic [NUM_FU-1:0] start;
  logic              legal_req;
  logic              target_busy;
  logic              grant;
  logic              smem_to;
  logic              mat_to;
  logic              alu_to_unused;
  logic              illegal_q;

  assign busy = {mat_state == SLOT_BUSY, smem_state == SLOT_BUSY, alu_state == SLOT_BUSY};

  // Combinational request decode: grant to an idle target, freeze on a busy one.
  always_comb begin
    legal_req   = disp.disp_valid & ~disp.flush & (disp.disp_fu != FU_ILLEGAL);
    target_busy = 1'b0;
    if (disp.disp_fu != FU_ILLEGAL) target_busy = busy[disp.disp_fu];
    grant       = legal_req & ~target_busy;
    start       = {grant & (disp.disp_fu == FU_MATRIX),
                   grant & (disp.disp_fu == FU_SMEM),
                   grant & (disp.disp_fu == FU_ALU)};
  end

  assign disp.grant       = grant;
  assign disp.freeze      = legal_req & target_busy;
  assign disp.fu_busy     = busy;
  assign disp.illegal_err = illegal_q;

  fu_slot #(.FIXED_LAT(1'b1), .LAT(ALU_LAT), .TIMEOUT(TIMEOUT)) u_alu (
    .clk(CLK), .rst_n(nRST), .start(start[FU_ALU]), .done(1'b0),
    .state(alu_state), .timeout_hit(alu_to_unused)
  );

  fu_slot #(.FIXED_LAT(1'b0), .LAT(0), .TIMEOUT(TIMEOUT)) u_smem (
    .clk(CLK), .rst_n(nRST), .start(start[FU_SMEM]), .done(smem_done),
    .state(smem_state), .timeout_hit(smem_to)
  );

  fu_slot #(.FIXED_LAT(1'b0), .LAT(0), .TIMEOUT(TIMEOUT)) u_mat (
    .clk(CLK), .rst_n(nRST), .start(start[FU_MATRIX]), .done(mat_done),
    .state(mat_state), .timeout_hit(mat_to)
  );

  // Illegal-code pulse, sticky timeout flags and wrapping grant counter.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      illegal_q   <= 1'b0;
      timeout_err <= 2'b00;
      issue_cnt   <= 16'h0000;
    end else begin
      illegal_q   <= disp.disp_valid & ~disp.flush & (disp.disp_fu == FU_ILLEGAL);
      timeout_err <= timeout_err | {mat_to, smem_to};
      if (grant) issue_cnt <= issue_cnt + 16'h0001;
    end
  end

endmodule

// File: tb/tb_fu_scheduler.sv
// Bench for fu_scheduler: directed vectors with literal expectations plus a
// cycle-level model compared against the main instance on every falling edge.
module tb_fu_scheduler;
  import types_pkg::*;

  localparam int ALU_LAT  = 2;
  localparam int TIMEOUT  = 6;
  localparam int TIMEOUT2 = 4;

  // ---------------- clock / reset ----------------
  logic CLK  = 1'b0;
  logic nRST = 1'b0;
  always #5 CLK = ~CLK;

  logic        smem_done, mat_done, smem_done2, mat_done2;
  logic [1:0]  timeout_err, timeout_err2;
  logic [15:0] issue_cnt, issue_cnt2;

  fu_scheduler_if bus();
  fu_scheduler_if bus2();

  fu_scheduler #(.ALU_LAT(ALU_LAT), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .nRST(nRST), .disp(bus), .smem_done(smem_done), .mat_done(mat_done),
    .timeout_err(timeout_err), .issue_cnt(issue_cnt)
  );

  fu_scheduler #(.ALU_LAT(ALU_LAT), .TIMEOUT(TIMEOUT2)) dut_to (
    .CLK(CLK), .nRST(nRST), .disp(bus2), .smem_done(smem_done2), .mat_done(mat_done2),
    .timeout_err(timeout_err2), .issue_cnt(issue_cnt2)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input fu_t fu, input logic fl, input logic sd, input logic md);
    bus.disp_valid = v;
    bus.disp_fu    = fu;
    bus.flush      = fl;
    smem_done      = sd;
    mat_done       = md;
  endtask

  task automatic drive2(input logic v, input fu_t fu, input logic md);
    bus2.disp_valid = v;
    bus2.disp_fu    = fu;
    bus2.flush      = 1'b0;
    smem_done2      = 1'b0;
    mat_done2       = md;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // ---------------- behavioural model + scoreboard ----------------
  // Each FU is described by how long it has left (ALU) or how long it has
  // been occupied (SMEM/MATRIX); the outputs follow from those quantities.
  int          alu_left;
  bit          smem_b, mat_b;
  int          smem_age, mat_age;
  bit          ill_exp;
  bit [1:0]    terr_exp;
  int unsigned cnt_exp;

  always @(negedge CLK) begin : compare
    logic [2:0] eb;
    logic       req, blk, eg, ef;
    if (!nRST) begin
      alu_left = 0; smem_b = 0; mat_b = 0; smem_age = 0; mat_age = 0;
      ill_exp = 0; terr_exp = 2'b00; cnt_exp = 0;
    end
    eb  = {mat_b, smem_b, (alu_left > 0)};
    req = bus.disp_valid && !bus.flush && (bus.disp_fu != FU_ILLEGAL);
    blk = req ? eb[bus.disp_fu] : 1'b0;
    eg  = req && !blk;
    ef  = req && blk;
    chk("m_grant",   bus.grant,       eg);
    chk("m_freeze",  bus.freeze,      ef);
    chk("m_fu_busy", bus.fu_busy,     eb);
    chk("m_illegal", bus.illegal_err, ill_exp);
    chk("m_timeout", timeout_err,     terr_exp);
    chk("m_issue",   issue_cnt,       cnt_exp);
    if (nRST) begin
      if (eg && bus.disp_fu == FU_ALU) alu_left = ALU_LAT;
      else if (alu_left > 0)           alu_left--;
      if (smem_b) begin
        if (smem_done)               smem_b = 0;
        else if (smem_age == TIMEOUT) begin smem_b = 0; terr_exp[0] = 1'b1; end
        else                         smem_age++;
      end else if (eg && bus.disp_fu == FU_SMEM) begin
        smem_b = 1; smem_age = 1;
      end
      if (mat_b) begin
        if (mat_done)                mat_b = 0;
        else if (mat_age == TIMEOUT) begin mat_b = 0; terr_exp[1] = 1'b1; end
        else                         mat_age++;
      end else if (eg && bus.disp_fu == FU_MATRIX) begin
        mat_b = 1; mat_age = 1;
      end
      ill_exp = bus.disp_valid && !bus.flush && (bus.disp_fu == FU_ILLEGAL);
      if (eg) cnt_exp = (cnt_exp + 1) % 65536;
    end
  end

  // ---------------- directed stimulus ----------------
  initial begin
    drive(0, FU_ALU, 0, 0, 0);
    drive2(0, FU_ALU, 0);
    repeat (2) @(posedge CLK);
    #2;
    chk("rst_busy",    bus.fu_busy, 3'b000);
    chk("rst_illegal", bus.illegal_err, 1'b0);
    chk("rst_timeout", timeout_err, 2'b00);
    chk("rst_issue",   issue_cnt, 16'h0000);
    @(posedge CLK);
    #1 nRST = 1'b1;

    // ALU fixed latency: busy cycles 1-2, retry at cycle 1 frozen.
    drive(1, FU_ALU, 0, 0, 0); #1 chk("alu_grant0", bus.grant, 1'b1); tick();
    drive(1, FU_ALU, 0, 0, 0); #1;
    chk("alu_busy1", bus.fu_busy, 3'b001);
    chk("alu_freeze1", bus.freeze, 1'b1);
    chk("alu_nogrant1", bus.grant, 1'b0);
    tick();
    drive(0, FU_ALU, 0, 0, 0); #1 chk("alu_busy2", bus.fu_busy[0], 1'b1); tick();
    #1 chk("alu_free3", bus.fu_busy[0], 1'b0);
    chk("alu_issue", issue_cnt, 16'd1);

    // SMEM: done at cycle 5, freed cycle 6.
    drive(1, FU_SMEM, 0, 0, 0); #1 chk("smem_grant0", bus.grant, 1'b1); tick();
    drive(0, FU_ALU, 0, 0, 0);
    repeat (4) tick();
    drive(1, FU_SMEM, 0, 1, 0); #1;
    chk("smem_freeze5", bus.freeze, 1'b1);
    chk("smem_nogrant5", bus.grant, 1'b0);
    chk("smem_busy5", bus.fu_busy[1], 1'b1);
    tick();
    drive(1, FU_SMEM, 0, 0, 0); #1;
    chk("smem_free6", bus.fu_busy[1], 1'b0);
    chk("smem_grant6", bus.grant, 1'b1);
    tick();
    drive(0, FU_ALU, 0, 1, 0); tick();
    // done while idle is ignored: granted SMEM still goes busy.
    drive(1, FU_SMEM, 0, 1, 0); tick();
    drive(0, FU_ALU, 0, 0, 0); #1 chk("smem_idle_done", bus.fu_busy[1], 1'b1); tick();
    drive(0, FU_ALU, 0, 1, 0); tick();
    drive(0, FU_ALU, 0, 0, 0);

    // SMEM timeout on the main instance (TIMEOUT=6).
    drive(1, FU_SMEM, 0, 0, 0); tick();
    drive(0, FU_ALU, 0, 0, 0);
    repeat (5) tick();
    #1 chk("smem_to_busy6", bus.fu_busy[1], 1'b1); tick();
    #1 chk("smem_to_free7", bus.fu_busy[1], 1'b0);
    chk("smem_to_err", timeout_err, 2'b01);

    // Illegal code: no grant/freeze, pulse next cycle only.
    drive(1, FU_ILLEGAL, 0, 0, 0); #1;
    chk("ill_grant", bus.grant, 1'b0);
    chk("ill_freeze", bus.freeze, 1'b0);
    chk("ill_now", bus.illegal_err, 1'b0);
    tick();
    drive(0, FU_ALU, 0, 0, 0); #1 chk("ill_pulse", bus.illegal_err, 1'b1); tick();
    #1 chk("ill_clear", bus.illegal_err, 1'b0);

    // Flush against a busy ALU: no freeze, no grant, ALU stays busy.
    drive(1, FU_ALU, 0, 0, 0); tick();
    drive(1, FU_ALU, 1, 0, 0); #1;
    chk("flush_freeze", bus.freeze, 1'b0);
    chk("flush_grant", bus.grant, 1'b0);
    chk("flush_busy", bus.fu_busy, 3'b001);
    tick();
    drive(1, FU_ILLEGAL, 1, 0, 0); tick();
    drive(0, FU_ALU, 0, 0, 0); #1 chk("flush_ill", bus.illegal_err, 1'b0); tick();

    // Second instance, TIMEOUT=4: done on the timeout edge, then a real timeout.
    drive2(1, FU_MATRIX, 0); #1 chk("t4_grant", bus2.grant, 1'b1); tick();
    drive2(0, FU_ALU, 0);
    repeat (3) tick();
    drive2(0, FU_ALU, 1); #1 chk("t4_busy4a", bus2.fu_busy[2], 1'b1); tick();
    drive2(0, FU_ALU, 0); #1;
    chk("t4_done_free", bus2.fu_busy[2], 1'b0);
    chk("t4_done_noerr", timeout_err2, 2'b00);
    tick();
    drive2(1, FU_MATRIX, 0); tick();
    drive2(0, FU_ALU, 0);
    repeat (3) tick();
    #1 chk("t4_busy4b", bus2.fu_busy[2], 1'b1); tick();
    #1 chk("t4_to_free", bus2.fu_busy[2], 1'b0);
    chk("t4_to_err", timeout_err2, 2'b10);
    repeat (3) tick();
    #1 chk("t4_sticky", timeout_err2, 2'b10);
    chk("t4_issue", issue_cnt2, 16'd2);

    // Asynchronous reset while SMEM busy.
    drive(1, FU_SMEM, 0, 0, 0); tick();
    #1 chk("rstmid_freeze", bus.freeze, 1'b1);
    nRST = 1'b0; #1;
    chk("rstmid_busy", bus.fu_busy, 3'b000);
    chk("rstmid_grant", bus.grant, 1'b1);
    chk("rstmid_freeze0", bus.freeze, 1'b0);
    chk("rstmid_timeout", timeout_err, 2'b00);
    chk("rstmid_issue", issue_cnt, 16'h0000);
    tick();
    drive(0, FU_ALU, 0, 0, 0); tick();
    nRST = 1'b1;

    // Counter wrap: alternate SMEM/MATRIX with done held high -> grant every cycle.
    for (int i = 0; i < 65535; i++) begin
      drive(1, (i % 2) ? FU_MATRIX : FU_SMEM, 0, 1, 1);
      tick();
    end
    drive(0, FU_ALU, 0, 0, 0); #1 chk("wrap_ffff", issue_cnt, 16'hFFFF);
    drive(1, FU_ALU, 0, 0, 0); #1 chk("wrap_grant", bus.grant, 1'b1); tick();
    drive(0, FU_ALU, 0, 0, 0); #1 chk("wrap_zero", issue_cnt, 16'h0000);
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
